// File: rtl/imagine_dbg_pkg.sv
// Shared encodings for the ImagineThinker run/step/breakpoint controller.
package imagine_dbg_pkg;

    localparam int unsigned CMD_OP_W = 2;
    localparam int unsigned CAUSE_W  = 2;

    // Host command opcodes carried on cmd_op
    typedef enum logic [CMD_OP_W-1:0] {
        CMD_HALT = 2'd0,
        CMD_RUN  = 2'd1,
        CMD_STEP = 2'd2,
        CMD_CLR  = 2'd3
    } cmd_op_e;

    // Reason the controller last entered HALTED
    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE      = 2'd0,
        CAUSE_HOST      = 2'd1,
        CAUSE_BP        = 2'd2,
        CAUSE_STEP_DONE = 2'd3
    } halt_cause_e;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } state_e;

endpackage : imagine_dbg_pkg

// File: rtl/imagine_step_ctrl_if.sv
// Host/debug and core-side signal bundle for imagine_step_ctrl.
interface imagine_step_ctrl_if #(
    parameter int unsigned PC_W        = 16,
    parameter int unsigned INST_W      = 32,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned NUM_BP      = 2,
    parameter int unsigned TRACE_DEPTH = 8
);
    localparam int unsigned TCNT_W = $clog2(TRACE_DEPTH) + 1;

    // host command channel
    logic                     cmd_valid;
    logic [1:0]               cmd_op;
    logic [CNT_W-1:0]         cmd_count;
    // breakpoint setup
    logic [NUM_BP-1:0]        bp_en;
    logic [NUM_BP*PC_W-1:0]   bp_addr;
    // core side
    logic [PC_W-1:0]          core_pc;
    logic [INST_W-1:0]        core_inst;
    logic                     core_ce;
    // status
    logic                     halted;
    logic [1:0]               halt_cause;
    logic [CNT_W-1:0]         steps_done;
    // trace readout
    logic                     trace_rd_en;
    logic [PC_W+INST_W-1:0]   trace_rd_data;
    logic                     trace_empty;
    logic [TCNT_W-1:0]        trace_count;
    logic                     trace_ovf;

    // controller side
    modport slave (
        input  cmd_valid, cmd_op, cmd_count, bp_en, bp_addr,
        input  core_pc, core_inst, trace_rd_en,
        output core_ce, halted, halt_cause, steps_done,
        output trace_rd_data, trace_empty, trace_count, trace_ovf
    );

    // host / core model side
    modport master (
        output cmd_valid, cmd_op, cmd_count, bp_en, bp_addr,
        output core_pc, core_inst, trace_rd_en,
        input  core_ce, halted, halt_cause, steps_done,
        input  trace_rd_data, trace_empty, trace_count, trace_ovf
    );

endinterface : imagine_step_ctrl_if

// File: rtl/imagine_trace_ring.sv
// Overwrite-on-full circular buffer with show-ahead read, clear, count and
// sticky overflow flag.
module imagine_trace_ring #(
    parameter int unsigned DATA_W = 48,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clr,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_ovf
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_drop;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_do_pop = i_pop && !w_empty;
    // a push into a full ring with no pop discards the oldest entry
    assign w_drop   = i_push && w_full && !i_pop;

    // storage: when full the write slot coincides with the head slot
    always_ff @(posedge clk) begin
        if (i_push && !i_clr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // pointers, occupancy and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop || w_drop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (i_push && !w_do_pop && !w_full) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !i_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule : imagine_trace_ring

// File: rtl/imagine_step_ctrl.sv
// Run/step/breakpoint controller: drives the core clock-enable from host
// commands, halts on PC breakpoints and traces executed {pc, inst} pairs.
module imagine_step_ctrl
    import imagine_dbg_pkg::*;
#(
    parameter int unsigned PC_W        = 16,
    parameter int unsigned INST_W      = 32,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned NUM_BP      = 2,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    imagine_step_ctrl_if.slave  dbg
);
    localparam int unsigned TRACE_W = PC_W + INST_W;

    state_e            r_state;
    halt_cause_e       r_cause;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_skip;
    logic [CNT_W-1:0]  r_steps;

    state_e            w_next_state;
    halt_cause_e       w_next_cause;
    logic [CNT_W-1:0]  w_next_cnt;
    logic              w_next_skip;

    logic w_bp_match;
    logic w_bp_hit;
    logic w_ce;
    logic w_cmd_halt;
    logic w_cmd_run;
    logic w_cmd_step;
    logic w_cmd_clr;

    assign w_cmd_halt = dbg.cmd_valid && (dbg.cmd_op == CMD_HALT);
    assign w_cmd_run  = dbg.cmd_valid && (dbg.cmd_op == CMD_RUN);
    assign w_cmd_step = dbg.cmd_valid && (dbg.cmd_op == CMD_STEP);
    assign w_cmd_clr  = dbg.cmd_valid && (dbg.cmd_op == CMD_CLR);

    // breakpoint comparators against the PC about to execute
    always_comb begin
        w_bp_match = 1'b0;
        for (int i = 0; i < int'(NUM_BP); i++) begin
            if (dbg.bp_en[i] && (dbg.core_pc == dbg.bp_addr[i*PC_W +: PC_W])) begin
                w_bp_match = 1'b1;
            end
        end
    end

    // skip masks the breakpoint so execution can resume from a breakpointed PC
    assign w_bp_hit = w_bp_match && !r_skip;
    assign w_ce     = ((r_state == ST_RUN) || (r_state == ST_STEP)) && !w_bp_hit;

    // next-state: breakpoint beats step completion beats host halt
    always_comb begin
        w_next_state = r_state;
        w_next_cause = r_cause;
        w_next_cnt   = r_cnt;
        w_next_skip  = r_skip;
        case (r_state)
            ST_HALTED: begin
                if (w_cmd_run) begin
                    w_next_state = ST_RUN;
                    w_next_skip  = 1'b1;
                end else if (w_cmd_step) begin
                    if (dbg.cmd_count != '0) begin
                        w_next_state = ST_STEP;
                        w_next_cnt   = dbg.cmd_count;
                        w_next_skip  = 1'b1;
                    end else begin
                        w_next_cause = CAUSE_STEP_DONE;
                    end
                end else if (w_cmd_halt) begin
                    w_next_cause = CAUSE_HOST;
                end
            end
            ST_RUN: begin
                w_next_skip = 1'b0;
                if (w_bp_hit) begin
                    w_next_state = ST_HALTED;
                    w_next_cause = CAUSE_BP;
                end else if (w_cmd_halt) begin
                    w_next_state = ST_HALTED;
                    w_next_cause = CAUSE_HOST;
                end
            end
            ST_STEP: begin
                w_next_skip = 1'b0;
                if (w_bp_hit) begin
                    w_next_state = ST_HALTED;
                    w_next_cause = CAUSE_BP;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_next_state = ST_HALTED;
                        w_next_cause = CAUSE_STEP_DONE;
                    end else if (w_cmd_halt) begin
                        w_next_state = ST_HALTED;
                        w_next_cause = CAUSE_HOST;
                    end
                end
            end
            default: begin
                w_next_state = ST_HALTED;
            end
        endcase
    end

    // FSM and step-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HALTED;
            r_cause <= CAUSE_NONE;
            r_cnt   <= '0;
            r_skip  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cause <= w_next_cause;
            r_cnt   <= w_next_cnt;
            r_skip  <= w_next_skip;
        end
    end

    // executed-cycle counter, cleared by CLR even when a cycle executes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_steps <= '0;
        end else if (w_cmd_clr) begin
            r_steps <= '0;
        end else if (w_ce) begin
            r_steps <= r_steps + CNT_W'(1);
        end
    end

    imagine_trace_ring #(
        .DATA_W (TRACE_W),
        .DEPTH  (TRACE_DEPTH)
    ) u_trace (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_ce),
        .i_pop   (dbg.trace_rd_en),
        .i_clr   (w_cmd_clr),
        .i_data  ({dbg.core_pc, dbg.core_inst}),
        .o_data  (dbg.trace_rd_data),
        .o_empty (dbg.trace_empty),
        .o_count (dbg.trace_count),
        .o_ovf   (dbg.trace_ovf)
    );

    assign dbg.core_ce    = w_ce;
    assign dbg.halted     = (r_state == ST_HALTED);
    assign dbg.halt_cause = r_cause;
    assign dbg.steps_done = r_steps;

endmodule : imagine_step_ctrl

// File: doc/imagine_step_ctrl.md
# imagine_step_ctrl

Synthesizable run/step/breakpoint controller for the ImagineThinker core. It replaces hand-toggled bench clocking with a clock-enable that a host drives by command: free-run, step N cycles, or halt. It halts on any of NUM_BP PC breakpoints and records executed {PC, instruction} pairs in a trace ring buffer. It sits between the host/debug port and the core's clock-enable, PC and next-instruction outputs.

## Interface
- PC_W, 16, core PC width
- INST_W, 32, core instruction width
- CNT_W, 16, step count and steps_done width
- NUM_BP, 2, number of PC breakpoint comparators
- TRACE_DEPTH, 8, trace entries; power of two, at least 2
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command strobe; always accepted (no ready)
- cmd_op  in  2  0 HALT, 1 RUN, 2 STEP, 3 CLR
- cmd_count  in  CNT_W  step count for STEP
- bp_en  in  NUM_BP  per-comparator enable
- bp_addr  in  NUM_BP*PC_W  breakpoint addresses; comparator i uses slice i
- core_pc  in  PC_W  core PC (PC of the instruction about to execute)
- core_inst  in  INST_W  core nextInst
- core_ce  out  1  core clock-enable
- halted  out  1  high in HALTED state
- halt_cause  out  2  0 NONE, 1 HOST, 2 BP, 3 STEP_DONE
- steps_done  out  CNT_W  count of core_ce cycles; wraps at 2^CNT_W
- trace_rd_en  in  1  pop oldest trace entry
- trace_rd_data  out  PC_W+INST_W  oldest entry {pc, inst}; show-ahead; valid when !trace_empty
- trace_empty  out  1  trace ring empty
- trace_count  out  $clog2(TRACE_DEPTH)+1  number of entries held
- trace_ovf  out  1  sticky; set when an entry is overwritten

## Operation
- States: HALTED, RUN, STEP.
- Reset values: HALTED, halt_cause 0, core_ce 0, steps_done 0, trace empty, trace_count 0, trace_ovf 0, step counter 0, skip flag 0.
- bp_hit = OR over i of (bp_en[i] && core_pc == bp_addr[i]) && !skip.
- core_ce = (state is RUN or STEP) && !bp_hit.
- HALTED + RUN goes to RUN and sets skip.
- HALTED + STEP with cmd_count K>0 goes to STEP, loads counter with K and sets skip.
- HALTED + STEP with K=0 stays HALTED and sets cause STEP_DONE.
- skip clears after the first RUN/STEP cycle. Setting skip lets execution resume from a breakpointed PC.
- RUN or STEP with bp_hit goes to HALTED with cause BP. No instruction executes that cycle.
- STEP: the counter decrements on every core_ce cycle. The cycle it decrements from 1 to 0, the next state is HALTED with cause STEP_DONE.
- HALT in any state goes to HALTED with cause HOST.
- RUN or STEP received while not HALTED is ignored.
- CLR in any state empties the trace and clears trace_ovf and steps_done. State and cause are unchanged.
- Priority within one cycle: bp_hit over STEP_DONE over HOST HALT.
- Trace: every core_ce cycle pushes {core_pc, core_inst}.
  - Full, push, no pop: the oldest entry is discarded, trace_ovf is set, count is unchanged.
  - Full, push and pop together: the popped entry is the current head, the new entry is written, count is unchanged, no overflow.
  - Pop when empty is ignored.
  - CLR together with a push: CLR wins and the trace ends empty.
- steps_done increments on every core_ce cycle. CLR together with an increment gives 0.

## Timing
- A command sampled at edge N changes state at edge N. The effect is visible on core_ce in the cycle after edge N.
- STEP K: core_ce is high for exactly K consecutive cycles unless a breakpoint hits. halted rises at the edge ending the Kth cycle.
- core_ce is combinational from state, skip, core_pc and bp registers. There is a single-cycle path from core_pc.
- A trace push lands at the edge of the core_ce cycle. trace_rd_data updates the cycle after a pop or after the first push into an empty ring.
- Asserting rst_n low mid-RUN drops core_ce immediately (asynchronously) and clears all state.

## Structure
- imagine_dbg_pkg holds:
  - cmd_op encodings
  - halt_cause encodings
  - the state enum
- Sub-module imagine_trace_ring: parametrised overwrite-on-full circular buffer with show-ahead read, clear, count and overflow flag. The top holds only the FSM, counters and comparators.

## Test plan
- Reset, then RUN with core_pc incrementing from 0 and bp0=0x0005 enabled. Required: core_ce high for PCs 0 to 4; halted with cause BP at pc 5; steps_done=5; trace holds pcs 0 to 4.
- From the bp0 halt, issue STEP 3. Required: the skip flag lets pc 5 execute; core_ce high for exactly 3 cycles; cause STEP_DONE; steps_done=8.
- STEP with cmd_count=0. Required: core_ce stays 0 and cause becomes STEP_DONE.
- With TRACE_DEPTH=8, RUN for 10 cycles then HALT. Required: trace_count=8, trace_ovf=1, oldest pc=2; cause HOST.
- While full, push and pop in the same cycle. Required: the popped entry is the old head, count stays 8, trace_ovf is unchanged.
- Drop rst_n mid-RUN. Required: core_ce falls before the next edge; after release, halted=1, cause 0, trace empty.
